// File: rtl/dpram_arbiter_pkg.sv
// Shared types and sizing for the dual-port RAM controller.
// Two-requester round-robin arbitration for both RAM ports.
package dpram_arbiter_pkg;

  localparam int RAM_WIDTH = 8;
  localparam int RAM_DEPTH = 16;
  localparam int ADDR_SIZE = 4;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dpram_arbiter_if.sv
// Client-side bundle of the controller: two writers, two readers, read return and busy.
// Clients use the master modport, the controller uses the slave modport.
interface dpram_arbiter_if;
  import dpram_arbiter_pkg::*;

  logic [1:0]           wr_req;
  logic [ADDR_SIZE-1:0] wr_addr0;
  logic [ADDR_SIZE-1:0] wr_addr1;
  logic [RAM_WIDTH-1:0] wr_data0;
  logic [RAM_WIDTH-1:0] wr_data1;
  logic [1:0]           wr_gnt;

  logic [1:0]           rd_req;
  logic [ADDR_SIZE-1:0] rd_addr0;
  logic [ADDR_SIZE-1:0] rd_addr1;
  logic [1:0]           rd_gnt;

  logic [RAM_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_id;
  logic                 busy;

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req, rd_addr0, rd_addr1,
    input  wr_gnt, rd_gnt, rd_data, rd_valid, rd_id, busy
  );

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req, rd_addr0, rd_addr1,
    output wr_gnt, rd_gnt, rd_data, rd_valid, rd_id, busy
  );

endinterface

// File: rtl/dpram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer names the
// requester that wins the next tie and moves to the loser after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_r;

  // grant selection from the request pair and the tie-break pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // pointer moves to the requester that was not served
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (gnt[0]) begin
      ptr_r <= 1'b1;
    end else if (gnt[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Owns a 16x8 dual-port RAM: zero-fills it after reset, then shares the write
// and read ports between two requesters each, returning read data with an ID.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dpram_arbiter_if.slave       bus,
  output logic                 ram_write,
  output logic                 ram_read,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  state_e               state_r;
  logic [ADDR_SIZE-1:0] init_addr_r;
  logic                 run_s;

  logic [1:0]           wr_gnt_s;
  logic [1:0]           rd_gnt_s;
  logic [ADDR_SIZE-1:0] wr_addr_sel_s;
  logic [RAM_WIDTH-1:0] wr_data_sel_s;
  logic [ADDR_SIZE-1:0] rd_addr_sel_s;
  logic                 collide_s;

  logic                 rd_valid_r;
  logic                 rd_id_r;
  logic                 bypass_r;
  logic [RAM_WIDTH-1:0] bypass_data_r;

  assign run_s = (state_r == RUN);

  rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .en  (run_s),
    .req (bus.wr_req),
    .gnt (wr_gnt_s)
  );

  rr_arb2 u_rd_arb (
    .clk (clk),
    .rst (rst),
    .en  (run_s),
    .req (bus.rd_req),
    .gnt (rd_gnt_s)
  );

  // select address/data of whichever requester holds each grant
  always_comb begin
    wr_addr_sel_s = bus.wr_addr0;
    wr_data_sel_s = bus.wr_data0;
    rd_addr_sel_s = bus.rd_addr0;
    if (wr_gnt_s[1]) begin
      wr_addr_sel_s = bus.wr_addr1;
      wr_data_sel_s = bus.wr_data1;
    end else begin
      wr_addr_sel_s = bus.wr_addr0;
      wr_data_sel_s = bus.wr_data0;
    end
    if (rd_gnt_s[1]) begin
      rd_addr_sel_s = bus.rd_addr1;
    end else begin
      rd_addr_sel_s = bus.rd_addr0;
    end
  end

  assign collide_s = (|wr_gnt_s) && (|rd_gnt_s) && (wr_addr_sel_s == rd_addr_sel_s);

  // RAM pin drive: zero-fill sweep during INIT, granted traffic during RUN
  always_comb begin
    ram_write   = 1'b0;
    ram_read    = 1'b0;
    ram_wr_addr = {ADDR_SIZE{1'b0}};
    ram_rd_addr = {ADDR_SIZE{1'b0}};
    ram_data_in = {RAM_WIDTH{1'b0}};
    if (state_r == INIT) begin
      ram_write   = 1'b1;
      ram_wr_addr = init_addr_r;
      ram_data_in = {RAM_WIDTH{1'b0}};
    end else begin
      ram_write   = |wr_gnt_s;
      ram_read    = |rd_gnt_s;
      ram_wr_addr = wr_addr_sel_s;
      ram_rd_addr = rd_addr_sel_s;
      ram_data_in = wr_data_sel_s;
    end
  end

  // controller FSM: fill sweep stops at the last word, RUN holds until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      init_addr_r <= {ADDR_SIZE{1'b0}};
    end else begin
      case (state_r)
        INIT: begin
          if (init_addr_r == LAST_ADDR) begin
            state_r <= RUN;
          end else begin
            init_addr_r <= init_addr_r + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r     <= INIT;
          init_addr_r <= {ADDR_SIZE{1'b0}};
        end
      endcase
    end
  end

  // one-deep read return stage; same-address write wins through the bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r    <= 1'b0;
      rd_id_r       <= REQ0;
      bypass_r      <= 1'b0;
      bypass_data_r <= {RAM_WIDTH{1'b0}};
    end else begin
      rd_valid_r    <= |rd_gnt_s;
      rd_id_r       <= rd_gnt_s[1] ? REQ1 : REQ0;
      bypass_r      <= collide_s;
      bypass_data_r <= collide_s ? wr_data_sel_s : bypass_data_r;
    end
  end

  assign bus.wr_gnt   = wr_gnt_s;
  assign bus.rd_gnt   = rd_gnt_s;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_id    = rd_id_r;
  assign bus.rd_data  = bypass_r ? bypass_data_r : ram_data_out;
  assign bus.busy     = (state_r == INIT);

endmodule
